ex_forward_unit: RTL and testbench
==================================

# ex_forward_unit

Execute-stage operand forwarding and load-use interlock for the 20-bit pipelined processor. Consumes the source/destination register tags and register-file operands presented by the ID/EX pipeline register. Tracks the two younger stages (EX/MEM, MEM/WB) internally, delivers the correct ALU operands, and raises a one-cycle stall on a load-use hazard. It also drives the register-file write port from its MEM/WB tracking stage.

## Interface
- `DW`, 20: datapath width.
- `RW`, 4: register tag width (16 registers; r0 reads as zero and is never a forwarding target).
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all tracking state immediately.
- `id_ex_op1`  in  RW  source-1 tag of the instruction in EX.
- `id_ex_op2`  in  RW  source-2 tag of the instruction in EX.
- `id_ex_dest`  in  RW  destination tag of the instruction in EX.
- `id_ex_wr`  in  1  the EX instruction writes a register.
- `id_ex_load`  in  1  the EX instruction is a load.
- `data_rf1` / `data_rf2`  in  DW  register-file operands latched by ID/EX.
- `ex_result`  in  DW  ALU result of the EX instruction (combinational this cycle).
- `mem_rdata`  in  DW  synchronous data-memory read data; valid the cycle after the load occupies MEM.
- `fwd_a` / `fwd_b`  out  DW  forwarded ALU operands.
- `sel_a` / `sel_b`  out  2  source select: 0 RF, 1 EX/MEM, 2 MEM/WB.
- `stall`  out  1  load-use interlock; upstream holds PC, IF/ID and ID/EX.
- `wb_en`  out  1  register-file write enable.
- `wb_dest`  out  RW  register-file write tag.
- `wb_data`  out  DW  register-file write data.

## Operation
- EX/MEM tracker holds: `xm_dest`, `xm_wr`, `xm_load`, `xm_val`. On each edge it captures `id_ex_dest`, `id_ex_wr`, `id_ex_load` and `ex_result`. When `stall`=1 it captures a bubble instead: `xm_wr`=0, `xm_load`=0.
- MEM/WB tracker holds: `mw_dest`, `mw_wr`, `mw_load`, `mw_val`. On each edge it captures the EX/MEM tracker, with `mw_val` taken from `xm_val`.
- WB value: `mw_load` ? `mem_rdata` : `mw_val`.
- Match conditions:
  - EX/MEM hit for operand A: `xm_wr` & (`xm_dest`==`id_ex_op1`) & (`id_ex_op1`!=0). Operand B uses `id_ex_op2` in the same way.
  - MEM/WB hit for operand A: `mw_wr` & (`mw_dest`==`id_ex_op1`) & (`id_ex_op1`!=0). Operand B likewise.
- Priority: an EX/MEM hit with `xm_load`=0 gives sel=1, `xm_val`. Otherwise a MEM/WB hit gives sel=2, WB value. Otherwise sel=0, RF data.
- Load-use: `stall`=1 when an EX/MEM hit exists on either operand and `xm_load`=1. While `stall`=1, `fwd_*`/`sel_*` are don't-care. The EX instruction is re-presented next cycle, and the load has moved to MEM/WB by then, so the operand resolves through sel=2.
- Writeback: `wb_en`=`mw_wr` & (`mw_dest`!=0); `wb_dest`=`mw_dest`; `wb_data`=WB value.
- The register file writes on the edge, so a same-cycle read of `wb_dest` is covered by the MEM/WB forward path.

## Timing
- All outputs are combinational from the tracker registers and the current inputs; the block adds zero latency to EX.
- Producer-to-consumer distance:
  - 1 cycle, ALU producer: forwarded from EX/MEM.
  - 2 cycles: forwarded from MEM/WB.
  - 3 or more cycles: read from RF.
  - 1 cycle, load producer: exactly one stall cycle, then forwarded from MEM/WB.
- `stall` never lasts more than one cycle per load, because the bubble clears `xm_load`.
- Reset, including mid-operation:
  - All tracker fields clear to 0, so `xm_wr`=`mw_wr`=0.
  - `stall`=0, `wb_en`=0, `wb_dest`=0, `sel_a`=`sel_b`=0.
  - `fwd_a`/`fwd_b` equal `data_rf1`/`data_rf2`.
  - `wb_data`=0 unless `mw_load`; `mw_load` is 0 after reset, so `wb_data`=0.
- Simultaneous hits in both trackers: EX/MEM wins (the younger value).
- Identical tags in op1 and op2: both operands resolve identically.

## Test plan
- ALU back-to-back: EX writes r3 with `ex_result`=0x00A5A; next cycle EX reads op1=r3 with `data_rf1`=0x11111 -> `sel_a`=1, `fwd_a`=0x00A5A, `stall`=0.
- Distance 2: r5 written with 0x12345, one unrelated instruction, then a reader of op2=r5 -> `sel_b`=2, `fwd_b`=0x12345. Same cycle: `wb_en`=1, `wb_dest`=5, `wb_data`=0x12345.
- Load-use: load to r7 followed by a reader of op1=r7 -> `stall`=1 for one cycle. The next cycle has `mem_rdata`=0xFEDCB -> `stall`=0, `sel_a`=2, `fwd_a`=0xFEDCB, `wb_en`=1, `wb_dest`=7.
- Double hit: r2 written with 0x00001, then r2 written with 0x00002, then a reader of op1=op2=r2 -> both sel=1, both operands 0x00002.
- r0 guard: writer to r0 with `ex_result`=0xFFFFF, then a reader of op1=r0 with `data_rf1`=0 -> `sel_a`=0, `fwd_a`=0. Two cycles later `wb_en`=0.
- Async reset mid-stream: assert `reset` between edges while `xm_wr`=1 and `stall`=1 -> immediately `stall`=0, `wb_en`=0, `sel_a`=`sel_b`=0. After release, the first edge resumes normal tracking.

Source files
------------

// File: rtl/ex_forward_unit.sv
// Execute-stage operand forwarding and load-use interlock.
// Tracks EX/MEM and MEM/WB internally and drives the register-file write port.
module ex_forward_unit #(
  parameter int unsigned DW = 20,
  parameter int unsigned RW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [RW-1:0] id_ex_op1,
  input  logic [RW-1:0] id_ex_op2,
  input  logic [RW-1:0] id_ex_dest,
  input  logic          id_ex_wr,
  input  logic          id_ex_load,
  input  logic [DW-1:0] data_rf1,
  input  logic [DW-1:0] data_rf2,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] fwd_a,
  output logic [DW-1:0] fwd_b,
  output logic [1:0]    sel_a,
  output logic [1:0]    sel_b,
  output logic          stall,
  output logic          wb_en,
  output logic [RW-1:0] wb_dest,
  output logic [DW-1:0] wb_data
);

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_XM = 2'd1;
  localparam logic [1:0] SEL_MW = 2'd2;

  logic [RW-1:0] xm_dest_q, xm_dest_d, mw_dest_q, mw_dest_d;
  logic          xm_wr_q, xm_wr_d, mw_wr_q, mw_wr_d;
  logic          xm_load_q, xm_load_d, mw_load_q, mw_load_d;
  logic [DW-1:0] xm_val_q, xm_val_d, mw_val_q, mw_val_d;

  logic [DW-1:0] wb_val;
  logic          xm_hit_a, xm_hit_b, mw_hit_a, mw_hit_b;

  // Tracker registers; reset clears every field so no stale forward survives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xm_dest_q <= '0;
      xm_wr_q   <= 1'b0;
      xm_load_q <= 1'b0;
      xm_val_q  <= '0;
      mw_dest_q <= '0;
      mw_wr_q   <= 1'b0;
      mw_load_q <= 1'b0;
      mw_val_q  <= '0;
    end else begin
      xm_dest_q <= xm_dest_d;
      xm_wr_q   <= xm_wr_d;
      xm_load_q <= xm_load_d;
      xm_val_q  <= xm_val_d;
      mw_dest_q <= mw_dest_d;
      mw_wr_q   <= mw_wr_d;
      mw_load_q <= mw_load_d;
      mw_val_q  <= mw_val_d;
    end
  end

  always_comb begin
    wb_val   = mw_load_q ? mem_rdata : mw_val_q;

    xm_hit_a = xm_wr_q && (xm_dest_q == id_ex_op1) && (id_ex_op1 != '0);
    xm_hit_b = xm_wr_q && (xm_dest_q == id_ex_op2) && (id_ex_op2 != '0);
    mw_hit_a = mw_wr_q && (mw_dest_q == id_ex_op1) && (id_ex_op1 != '0);
    mw_hit_b = mw_wr_q && (mw_dest_q == id_ex_op2) && (id_ex_op2 != '0);

    stall    = (xm_hit_a || xm_hit_b) && xm_load_q;

    // A stalled EX instruction enters EX/MEM as a bubble; it is re-presented next cycle.
    xm_dest_d = id_ex_dest;
    xm_wr_d   = id_ex_wr && !stall;
    xm_load_d = id_ex_load && !stall;
    xm_val_d  = ex_result;

    mw_dest_d = xm_dest_q;
    mw_wr_d   = xm_wr_q;
    mw_load_d = xm_load_q;
    mw_val_d  = xm_val_q;

    sel_a = SEL_RF;
    fwd_a = data_rf1;
    if (xm_hit_a && !xm_load_q) begin
      sel_a = SEL_XM;
      fwd_a = xm_val_q;
    end else if (mw_hit_a) begin
      sel_a = SEL_MW;
      fwd_a = wb_val;
    end

    sel_b = SEL_RF;
    fwd_b = data_rf2;
    if (xm_hit_b && !xm_load_q) begin
      sel_b = SEL_XM;
      fwd_b = xm_val_q;
    end else if (mw_hit_b) begin
      sel_b = SEL_MW;
      fwd_b = wb_val;
    end

    wb_en   = mw_wr_q && (mw_dest_q != '0);
    wb_dest = mw_dest_q;
    wb_data = wb_val;
  end

endmodule

// File: tb/tb_ex_forward_unit.sv
// Scoreboard bench for ex_forward_unit: directed instruction stream, expectations
// queued by the driver and compared by an independent monitor.
module tb_ex_forward_unit;

  localparam int unsigned DW = 20;
  localparam int unsigned RW = 4;

  logic          clock, reset;
  logic [RW-1:0] id_ex_op1, id_ex_op2, id_ex_dest;
  logic          id_ex_wr, id_ex_load;
  logic [DW-1:0] data_rf1, data_rf2, ex_result, mem_rdata;
  logic [DW-1:0] fwd_a, fwd_b, wb_data;
  logic [1:0]    sel_a, sel_b;
  logic          stall, wb_en;
  logic [RW-1:0] wb_dest;

  ex_forward_unit #(.DW(DW), .RW(RW)) dut (
    .clock(clock), .reset(reset),
    .id_ex_op1(id_ex_op1), .id_ex_op2(id_ex_op2), .id_ex_dest(id_ex_dest),
    .id_ex_wr(id_ex_wr), .id_ex_load(id_ex_load),
    .data_rf1(data_rf1), .data_rf2(data_rf2),
    .ex_result(ex_result), .mem_rdata(mem_rdata),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .sel_a(sel_a), .sel_b(sel_b),
    .stall(stall), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data)
  );

  // mask: bit0 operand A, bit1 operand B, bit2 stall, bit3 writeback port
  typedef struct {
    string         name;
    logic [3:0]    mask;
    logic [1:0]    sel_a, sel_b;
    logic [DW-1:0] fwd_a, fwd_b;
    logic          stall, wb_en;
    logic [RW-1:0] wb_dest;
    logic [DW-1:0] wb_data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  event sample_ev;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, pending=%0d", exp_q.size());
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so a queued entry is compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock or sample_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.mask[0]) begin
          chk({e.name, ".sel_a"}, 32'(sel_a), 32'(e.sel_a));
          chk({e.name, ".fwd_a"}, 32'(fwd_a), 32'(e.fwd_a));
        end
        if (e.mask[1]) begin
          chk({e.name, ".sel_b"}, 32'(sel_b), 32'(e.sel_b));
          chk({e.name, ".fwd_b"}, 32'(fwd_b), 32'(e.fwd_b));
        end
        if (e.mask[2]) chk({e.name, ".stall"}, 32'(stall), 32'(e.stall));
        if (e.mask[3]) begin
          chk({e.name, ".wb_en"},   32'(wb_en),   32'(e.wb_en));
          chk({e.name, ".wb_dest"}, 32'(wb_dest), 32'(e.wb_dest));
          chk({e.name, ".wb_data"}, 32'(wb_data), 32'(e.wb_data));
        end
      end
    end
  end

  task automatic drive(input logic [RW-1:0] op1, input logic [RW-1:0] op2,
                       input logic [RW-1:0] dest, input logic wr, input logic ld,
                       input logic [DW-1:0] rf1, input logic [DW-1:0] rf2,
                       input logic [DW-1:0] exr, input logic [DW-1:0] mrd);
    id_ex_op1  = op1;
    id_ex_op2  = op2;
    id_ex_dest = dest;
    id_ex_wr   = wr;
    id_ex_load = ld;
    data_rf1   = rf1;
    data_rf2   = rf2;
    ex_result  = exr;
    mem_rdata  = mrd;
  endtask

  // One EX cycle: new inputs just after the edge.
  task automatic cyc(input logic [RW-1:0] op1, input logic [RW-1:0] op2,
                     input logic [RW-1:0] dest, input logic wr, input logic ld,
                     input logic [DW-1:0] rf1, input logic [DW-1:0] rf2,
                     input logic [DW-1:0] exr, input logic [DW-1:0] mrd);
    @(posedge clock);
    #1;
    drive(op1, op2, dest, wr, ld, rf1, rf2, exr, mrd);
  endtask

  task automatic nop();
    cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 20'h0, 20'h0, 20'h0, 20'h77777);
  endtask

  task automatic expect_out(input logic [3:0] mask,
                            input logic [1:0] sa, input logic [DW-1:0] fa,
                            input logic [1:0] sb, input logic [DW-1:0] fb,
                            input logic st, input logic we,
                            input logic [RW-1:0] wd, input logic [DW-1:0] wdat,
                            input string name);
    exp_t e;
    e.name = name; e.mask = mask;
    e.sel_a = sa; e.fwd_a = fa; e.sel_b = sb; e.fwd_b = fb;
    e.stall = st; e.wb_en = we; e.wb_dest = wd; e.wb_data = wdat;
    exp_q.push_back(e);
  endtask

  task automatic expect_wb(input logic we, input logic [RW-1:0] wd,
                           input logic [DW-1:0] wdat, input string name);
    expect_out(4'b1000, 2'd0, 20'h0, 2'd0, 20'h0, 1'b0, we, wd, wdat, name);
  endtask

  task automatic expect_stall(input logic st, input string name);
    expect_out(4'b0100, 2'd0, 20'h0, 2'd0, 20'h0, st, 1'b0, 4'd0, 20'h0, name);
  endtask

  initial begin
    reset = 1'b1;
    drive(4'd3, 4'd4, 4'd0, 1'b0, 1'b0, 20'h0AAAA, 20'h05555, 20'h0, 20'h77777);
    #1;
    expect_out(4'b1111, 2'd0, 20'h0AAAA, 2'd0, 20'h05555, 1'b0, 1'b0, 4'd0, 20'h0, "reset_state");
    @(negedge clock);
    #1 reset = 1'b0;
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 20'h0, 20'h0, 20'h0, 20'h77777);

    // ALU back-to-back
    cyc(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 20'h0, 20'h0, 20'h00A5A, 20'h77777);
    expect_stall(1'b0, "alu_writer");
    cyc(4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 20'h11111, 20'h22222, 20'h0, 20'h77777);
    expect_out(4'b1111, 2'd1, 20'h00A5A, 2'd0, 20'h22222, 1'b0, 1'b0, 4'd0, 20'h0, "alu_b2b");
    nop();
    expect_wb(1'b1, 4'd3, 20'h00A5A, "wb_r3");

    // Distance 2 on B, with a distance-1 ALU hit on A in the same cycle
    cyc(4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 20'h0, 20'h0, 20'h12345, 20'h77777);
    cyc(4'd0, 4'd0, 4'd6, 1'b1, 1'b0, 20'h0, 20'h0, 20'h0BEEF, 20'h77777);
    cyc(4'd6, 4'd5, 4'd0, 1'b0, 1'b0, 20'h33333, 20'h99999, 20'h0, 20'h77777);
    expect_out(4'b1111, 2'd1, 20'h0BEEF, 2'd2, 20'h12345, 1'b0, 1'b1, 4'd5, 20'h12345, "dist2");
    nop();
    expect_wb(1'b1, 4'd6, 20'h0BEEF, "wb_r6");

    // Load-use: one stall, then MEM/WB forward of the memory data
    cyc(4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 20'h0, 20'h0, 20'h55555, 20'h77777);
    cyc(4'd7, 4'd0, 4'd8, 1'b1, 1'b0, 20'h44444, 20'h10101, 20'h00808, 20'h77777);
    expect_stall(1'b1, "loaduse_stall");
    cyc(4'd7, 4'd0, 4'd8, 1'b1, 1'b0, 20'h44444, 20'h10101, 20'h00808, 20'hFEDCB);
    expect_out(4'b1111, 2'd2, 20'hFEDCB, 2'd0, 20'h10101, 1'b0, 1'b1, 4'd7, 20'hFEDCB, "loaduse_fwd");
    nop();
    expect_stall(1'b0, "loaduse_done");

    // Double hit: the younger EX/MEM value wins on both operands
    cyc(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 20'h0, 20'h0, 20'h00001, 20'h77777);
    cyc(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 20'h0, 20'h0, 20'h00002, 20'h77777);
    cyc(4'd2, 4'd2, 4'd0, 1'b0, 1'b0, 20'h0F0F0, 20'h0F0F0, 20'h0, 20'h77777);
    expect_out(4'b1111, 2'd1, 20'h00002, 2'd1, 20'h00002, 1'b0, 1'b1, 4'd2, 20'h00001, "double_hit");

    // r0 is never forwarded nor written back
    cyc(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 20'h0, 20'h0, 20'hFFFFF, 20'h77777);
    cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 20'h0, 20'h00033, 20'h0, 20'h77777);
    expect_out(4'b1111, 2'd0, 20'h0, 2'd0, 20'h00033, 1'b0, 1'b0, 4'd0, 20'h0, "r0_guard");
    nop();
    expect_wb(1'b0, 4'd0, 20'hFFFFF, "r0_wb");

    // Async reset while a load-use stall is pending
    cyc(4'd0, 4'd0, 4'd9, 1'b1, 1'b1, 20'h0, 20'h0, 20'h0, 20'h77777);
    cyc(4'd0, 4'd9, 4'd10, 1'b1, 1'b0, 20'h01234, 20'h06666, 20'h0ABCD, 20'h77777);
    expect_stall(1'b1, "pre_reset_stall");
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    expect_out(4'b1111, 2'd0, 20'h01234, 2'd0, 20'h06666, 1'b0, 1'b0, 4'd0, 20'h0, "async_reset");
    -> sample_ev;
    #1 reset = 1'b0;
    cyc(4'd10, 4'd0, 4'd0, 1'b0, 1'b0, 20'h02222, 20'h03333, 20'h0, 20'h77777);
    expect_out(4'b1111, 2'd1, 20'h0ABCD, 2'd0, 20'h03333, 1'b0, 1'b0, 4'd0, 20'h0, "post_reset");
    nop();
    expect_wb(1'b1, 4'd10, 20'h0ABCD, "post_reset_wb");

    @(negedge clock);
    @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
